// File: rtl/video_pkg.sv
// video_pkg: shared pixel layout, pattern encodings, bar colours and FSM states for the video source path
package video_pkg;
  localparam int C_W   = 10;
  localparam int R_LSB = 20;
  localparam int G_LSB = 10;
  localparam int B_LSB = 0;
  localparam logic [C_W-1:0] FULL = 10'h3FF;
  localparam logic [C_W-1:0] ZERO = 10'h000;
  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;
  localparam logic [29:0] WHITE   = {FULL, FULL, FULL};
  localparam logic [29:0] YELLOW  = {FULL, FULL, ZERO};
  localparam logic [29:0] CYAN    = {ZERO, FULL, FULL};
  localparam logic [29:0] GREEN   = {ZERO, FULL, ZERO};
  localparam logic [29:0] MAGENTA = {FULL, ZERO, FULL};
  localparam logic [29:0] RED     = {FULL, ZERO, ZERO};
  localparam logic [29:0] BLUE    = {ZERO, ZERO, FULL};
  localparam logic [29:0] BLACK   = {ZERO, ZERO, ZERO};
  // index 0 is the leftmost bar
  localparam logic [7:0][29:0] BAR_COLORS = {BLACK, BLUE, RED, MAGENTA, GREEN, CYAN, YELLOW, WHITE};
  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;
  function automatic logic [29:0] pack_rgb(input logic [C_W-1:0] r, input logic [C_W-1:0] g, input logic [C_W-1:0] b);
    logic [29:0] p;
    p = '0;
    p[R_LSB +: C_W] = r;
    p[G_LSB +: C_W] = g;
    p[B_LSB +: C_W] = b;
    return p;
  endfunction
endpackage

// File: rtl/pattern_pixel.sv
// pattern_pixel: combinational {R,G,B} value for one pixel of the selected test pattern
module pattern_pixel
  import video_pkg::*;
(
  input  logic [1:0]  pattern,
  input  logic [9:0]  x,
  input  logic        y5,
  input  logic [2:0]  bar,
  input  logic [29:0] solid_rgb,
  output logic [29:0] rgb
);
  // bars come from the tracked bar index, so no divide by bar width is needed
  always_comb
    rgb = pattern == PAT_BARS  ? BAR_COLORS[bar] :
          pattern == PAT_RAMP  ? pack_rgb(x, x, x) :
          pattern == PAT_CHECK ? {30{x[5] ^ y5}} :
                                 solid_rgb;
endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: AXI4-Stream test-frame source with blanking and back-pressure handling
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [29:0] solid_rgb,
  input  logic        m_axis_video_tready,
  output logic [31:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  output logic [15:0] frame_count,
  output logic        busy
);
  localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BLANK - 1);
  state_t state, state_d;
  logic [11:0] x, x_d, y, y_d, bcnt, bcnt_d;
  logic [2:0]  bar, bar_d;
  logic [15:0] blank, blank_d, frame_count_d;
  logic [1:0]  pat, pat_d;
  logic [29:0] solid, solid_d, rgb;
  logic [31:0] tdata_d;
  logic        tvalid_d, tuser_d, tlast_d, busy_d;
  logic        xfer, eol, step, hb_end, vb_end, start, load, restart_line;
  // the pixel generator sees the next coordinates so a loaded pixel matches its position
  pattern_pixel u_pixel (
    .pattern   (pat_d),
    .x         (x_d[9:0]),
    .y5        (y_d[5]),
    .bar       (bar_d),
    .solid_rgb (solid_d),
    .rgb       (rgb)
  );
  // next-state, counters and next output word; everything holds unless an event says otherwise
  always_comb begin
    xfer          = m_axis_video_tvalid & m_axis_video_tready;
    eol           = xfer && x == X_LAST;
    step          = xfer && x != X_LAST;
    hb_end        = state == HBLANK && blank == HB_LAST;
    vb_end        = state == VBLANK && blank == VB_LAST;
    start         = enable && (state == IDLE || vb_end);
    load          = start | step | hb_end;
    restart_line  = start | hb_end;
    x_d           = restart_line ? 12'd0 : step ? x + 12'd1 : x;
    y_d           = start ? 12'd0 : hb_end ? y + 12'd1 : y;
    bcnt_d        = restart_line ? 12'd0 : step ? (bcnt == BAR_LAST ? 12'd0 : bcnt + 12'd1) : bcnt;
    bar_d         = restart_line ? 3'd0 : (step && bcnt == BAR_LAST) ? bar + 3'd1 : bar;
    blank_d       = (state == HBLANK || state == VBLANK) ? blank + 16'd1 : 16'd0;
    pat_d         = start ? pattern_sel : pat;
    solid_d       = start ? solid_rgb : solid;
    tvalid_d      = load ? 1'b1 : eol ? 1'b0 : m_axis_video_tvalid;
    tuser_d       = load ? start : eol ? 1'b0 : m_axis_video_tuser;
    tlast_d       = load ? x_d == X_LAST : eol ? 1'b0 : m_axis_video_tlast;
    tdata_d       = load ? {2'b00, rgb} : m_axis_video_tdata;
    frame_count_d = (eol && y == Y_LAST) ? frame_count + 16'd1 : frame_count;
    state_d       = restart_line ? ACTIVE :
                    eol          ? (y == Y_LAST ? VBLANK : HBLANK) :
                    vb_end       ? IDLE : state;
    busy_d        = state_d != IDLE;
  end
  // all state and outputs are registered, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      x                   <= '0;
      y                   <= '0;
      bcnt                <= '0;
      bar                 <= '0;
      blank               <= '0;
      pat                 <= PAT_BARS;
      solid               <= '0;
      m_axis_video_tdata  <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tuser  <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
      frame_count         <= '0;
      busy                <= 1'b0;
    end else begin
      state               <= state_d;
      x                   <= x_d;
      y                   <= y_d;
      bcnt                <= bcnt_d;
      bar                 <= bar_d;
      blank               <= blank_d;
      pat                 <= pat_d;
      solid               <= solid_d;
      m_axis_video_tdata  <= tdata_d;
      m_axis_video_tvalid <= tvalid_d;
      m_axis_video_tuser  <= tuser_d;
      m_axis_video_tlast  <= tlast_d;
      frame_count         <= frame_count_d;
      busy                <= busy_d;
    end
  end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: randomized self-checking bench for video_pattern_gen against a pixel-rule model
module tb_video_pattern_gen;
  localparam int H = 16;
  localparam int V = 4;
  localparam int HB = 2;
  localparam int VB = 5;
  localparam int N = H * V;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tready = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [29:0] solid_rgb = '0;
  logic [31:0] tdata;
  logic        tvalid, tuser, tlast, busy;
  logic [15:0] frame_count;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_bad = 0;
  logic [31:0] q_data[$];
  bit          q_user[$];
  bit          q_last[$];
  int          q_cyc[$];

  video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .pattern_sel         (pattern_sel),
    .solid_rgb           (solid_rgb),
    .m_axis_video_tready (tready),
    .m_axis_video_tdata  (tdata),
    .m_axis_video_tvalid (tvalid),
    .m_axis_video_tuser  (tuser),
    .m_axis_video_tlast  (tlast),
    .frame_count         (frame_count),
    .busy                (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // expected pixel straight from the pattern rules
  function automatic logic [31:0] model(input int pat, input logic [29:0] solid, input int x, input int y);
    int bits[8] = '{7, 6, 3, 2, 5, 4, 1, 0};
    int b;
    logic [9:0] r;
    case (pat)
      0: begin
        b = bits[x / (H / 8)];
        return {2'b00, {10{b[2]}}, {10{b[1]}}, {10{b[0]}}};
      end
      1: begin
        r = 10'(x % 1024);
        return {2'b00, r, r, r};
      end
      2: return (((x / 32) ^ (y / 32)) % 2) != 0 ? 32'h3FFFFFFF : 32'h0;
      default: return {2'b00, solid};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic q_clear();
    q_data.delete();
    q_user.delete();
    q_last.delete();
    q_cyc.delete();
    stall_bad = 0;
  endtask

  // collects up to n transfers with tready at the given duty; records stall-stability violations
  task automatic capture(input int n, input int duty, input int budget);
    bit pv = 0;
    logic [31:0] pd = '0;
    logic pu = 0, pl = 0;
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (pv && !(tvalid === 1'b1 && tdata === pd && tuser === pu && tlast === pl)) stall_bad++;
      tready = $urandom_range(99) < duty;
      pv = tvalid && !tready;
      pd = tdata;
      pu = tuser;
      pl = tlast;
      if (tvalid === 1'b1 && tready) begin
        q_data.push_back(tdata);
        q_user.push_back(tuser);
        q_last.push_back(tlast);
        q_cyc.push_back(cyc);
        got++;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    tready = 1'b1;
    pattern_sel = 2'd0;
    solid_rgb = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (tvalid !== 0 || tuser !== 0 || tlast !== 0 || tdata !== 0 || frame_count !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL reset_values got v=%b u=%b l=%b d=%h fc=%h busy=%b exp all zero", tvalid, tuser, tlast, tdata, frame_count, busy);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (tvalid !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL reset_holds got v=%b busy=%b exp 0 0", tvalid, busy);
    end
    enable = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (tvalid !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL idle_without_enable got v=%b busy=%b exp 0 0", tvalid, busy);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    q_clear();
    enable = 1'b1;
    checks++;
    if (tvalid !== 0) begin
      failures++;
      $display("FAIL valid_before_sample got=%b exp=0", tvalid);
    end
    tick();
    checks++;
    if (tvalid !== 1 || tuser !== 1 || busy !== 1) begin
      failures++;
      $display("FAIL first_valid got v=%b u=%b busy=%b exp 1 1 1", tvalid, tuser, busy);
    end
    capture(N + 1, 100, 400);
    checks++;
    if (q_data.size() != N + 1) begin
      failures++;
      $display("FAIL free_count got=%0d exp=%0d", q_data.size(), N + 1);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (q_data[i] !== model(0, '0, i % H, i / H) || q_user[i] !== (i == 0) || q_last[i] !== (i % H == H - 1)) begin
          failures++;
          $display("FAIL free_px%0d got d=%h u=%b l=%b exp d=%h u=%b l=%b", i, q_data[i], q_user[i], q_last[i], model(0, '0, i % H, i / H), i == 0, i % H == H - 1);
        end
      end
      for (int l = 1; l < V; l++) begin
        checks++;
        if (q_cyc[l * H] - q_cyc[l * H - 1] != HB + 1) begin
          failures++;
          $display("FAIL hblank_gap%0d got=%0d exp=%0d", l, q_cyc[l * H] - q_cyc[l * H - 1], HB + 1);
        end
      end
      checks++;
      if (q_cyc[N] - q_cyc[0] != 75 || q_user[N] !== 1'b1) begin
        failures++;
        $display("FAIL frame_period got=%0d u=%b exp=75 u=1", q_cyc[N] - q_cyc[0], q_user[N]);
      end
      checks++;
      if (q_data[0] !== 32'h3FFFFFFF || q_data[14] !== 32'h0) begin
        failures++;
        $display("FAIL bar_corners got p0=%h p14=%h exp 3fffffff 00000000", q_data[0], q_data[14]);
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin
      failures++;
      $display("FAIL frame_count_one got=%0d exp=1", frame_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    q_clear();
    pattern_sel = 2'd1;
    enable = 1'b1;
    capture(N, 30, 4000);
    tready = 1'b1;
    checks++;
    if (q_data.size() != N) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=%0d", q_data.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (q_data[i] !== model(1, '0, i % H, i / H) || q_user[i] !== (i == 0) || q_last[i] !== (i % H == H - 1)) begin
          failures++;
          $display("FAIL bp_px%0d got d=%h u=%b l=%b exp d=%h", i, q_data[i], q_user[i], q_last[i], model(1, '0, i % H, i / H));
        end
      end
    end
    checks++;
    if (stall_bad != 0) begin
      failures++;
      $display("FAIL bp_stall_stable got=%0d unstable cycles exp=0", stall_bad);
    end
  endtask

  task automatic test_pattern_latch();
    do_reset();
    q_clear();
    enable = 1'b1;
    capture(20, 100, 200);
    pattern_sel = 2'd3;
    solid_rgb = 30'h155AA955;
    capture(N - 20, 100, 200);
    capture(N, 100, 200);
    checks++;
    if (q_data.size() != 2 * N) begin
      failures++;
      $display("FAIL latch_count got=%0d exp=%0d", q_data.size(), 2 * N);
    end else begin
      for (int i = 0; i < 2 * N; i++) begin
        logic [31:0] e;
        e = i < N ? model(0, '0, i % H, (i / H) % V) : 32'h155AA955;
        checks++;
        if (q_data[i] !== e || q_user[i] !== (i % N == 0)) begin
          failures++;
          $display("FAIL latch_px%0d got d=%h u=%b exp d=%h u=%b", i, q_data[i], q_user[i], e, i % N == 0);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int seen = 0;
    do_reset();
    q_clear();
    enable = 1'b1;
    capture(H + 5, 100, 200);
    enable = 1'b0;
    capture(N - H - 5, 100, 200);
    checks++;
    if (q_data.size() != N || q_last[N - 1] !== 1'b1) begin
      failures++;
      $display("FAIL drop_complete got=%0d last=%b exp=%0d last=1", q_data.size(), q_last.size() > 0 ? q_last[q_last.size() - 1] : 1'b0, N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (q_data[i] !== model(0, '0, i % H, i / H)) begin
          failures++;
          $display("FAIL drop_px%0d got=%h exp=%h", i, q_data[i], model(0, '0, i % H, i / H));
        end
      end
    end
    for (int k = 0; k < VB; k++) begin
      checks++;
      if (busy !== 1'b1 || tvalid !== 1'b0) begin
        failures++;
        $display("FAIL drop_vblank%0d got busy=%b v=%b exp 1 0", k, busy, tvalid);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle got busy=%b exp=0", busy);
    end
    for (int k = 0; k < 50; k++) begin
      if (tvalid === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || frame_count !== 16'd1) begin
      failures++;
      $display("FAIL drop_quiet got valids=%0d fc=%0d exp 0 1", seen, frame_count);
    end
  endtask

  task automatic test_reset_mid();
    q_clear();
    enable = 1'b1;
    capture(2 * H + 7, 100, 300);
    rst = 1'b1;
    #1;
    checks++;
    if (tvalid !== 0 || tuser !== 0 || tlast !== 0 || tdata !== 0 || frame_count !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL mid_reset got v=%b u=%b l=%b d=%h fc=%h busy=%b exp all zero", tvalid, tuser, tlast, tdata, frame_count, busy);
    end
    rst = 1'b0;
    tick();
    q_clear();
    capture(1, 100, 20);
    checks++;
    if (q_data.size() != 1 || q_data[0] !== 32'h3FFFFFFF || q_user[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_restart got n=%0d d=%h u=%b exp 1 3fffffff 1", q_data.size(), q_data.size() > 0 ? q_data[0] : 32'h0, q_user.size() > 0 ? q_user[0] : 1'b0);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    q_clear();
    force dut.frame_count = 16'hFFFF;
    tick();
    release dut.frame_count;
    enable = 1'b1;
    capture(N, 100, 300);
    enable = 1'b0;
    checks++;
    if (q_data.size() != N || frame_count !== 16'h0000) begin
      failures++;
      $display("FAIL counter_wrap got n=%0d fc=%h exp %0d 0000", q_data.size(), frame_count, N);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_pattern_latch();
    test_enable_drop();
    test_reset_mid();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
